// File: rtl/ifu_prefetch_queue.sv
// rtl/ifu_prefetch_queue.sv - pipelined instruction prefetch with DEPTH-entry queue and redirect flush
// Optional feature macro: IFU_ERR_TRAP_EN (per-entry bus error flag plus fetch stall until redirect).
module ifu_prefetch_queue #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_ifu_req_valid,
    input  logic            i_ifu_req_ready,
    output logic [XLEN-1:0] o_ifu_raddr,
    input  logic            i_ifu_resp_valid,
    input  logic [XLEN-1:0] i_ifu_rdata,
    input  logic            i_ifu_resp_err,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_inst_valid,
    input  logic            i_inst_ready,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic            o_inst_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] f_pc, r_pc, stale_addr;
    logic [CW-1:0]   count, inflight, drop, inflight_nxt;
    logic            pending, stale, err_stall;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic            err_mem  [DEPTH];
    logic            credit_ok, req_fire, resp_fire, push, pop, stale_fire;

    assign credit_ok = ({1'b0, count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
    // A request already on the bus must stay there until accepted, even across a redirect.
    assign o_ifu_req_valid = ~i_rst & (pending | (credit_ok & ~i_redirect & ~err_stall));
    assign o_ifu_raddr     = stale ? stale_addr : f_pc;

    assign req_fire     = o_ifu_req_valid & i_ifu_req_ready;
    assign stale_fire   = req_fire & stale;
    assign resp_fire    = i_ifu_resp_valid;
    assign push         = resp_fire & ~i_redirect & (drop == '0);
    assign o_inst_valid = (count != '0);
    assign pop          = o_inst_valid & i_inst_ready;
    assign inflight_nxt = inflight + CW'(req_fire) - CW'(resp_fire);

    assign o_inst = inst_mem[rd_ptr];
    assign o_pc   = pc_mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f_pc       <= RESET_PC;
            r_pc       <= RESET_PC;
            stale_addr <= RESET_PC;
            count      <= '0;
            inflight   <= '0;
            drop       <= '0;
            pending    <= 1'b0;
            stale      <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= RESET_PC;
                err_mem[i]  <= 1'b0;
            end
        end else begin
            inflight <= inflight_nxt;
            pending  <= o_ifu_req_valid & ~i_ifu_req_ready;
            if (i_redirect) begin
                f_pc       <= i_redirect_pc;
                r_pc       <= i_redirect_pc;
                stale      <= pending & ~i_ifu_req_ready;
                stale_addr <= o_ifu_raddr;
                drop       <= inflight_nxt;
                count      <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (req_fire && !stale) f_pc <= f_pc + XLEN'(4);
                if (i_ifu_req_ready) stale <= 1'b0;
                // A stale request fired after its redirect still owes a response to discard.
                drop  <= drop + CW'(stale_fire) - CW'(resp_fire && drop != '0);
                count <= count + CW'(push) - CW'(pop);
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push) begin
                    r_pc             <= r_pc + XLEN'(4);
                    wr_ptr           <= wr_ptr + 1'b1;
                    inst_mem[wr_ptr] <= i_ifu_rdata;
                    pc_mem[wr_ptr]   <= r_pc;
                    err_mem[wr_ptr]  <= i_ifu_resp_err;
                end
            end
        end
    end

`ifdef IFU_ERR_TRAP_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            err_stall <= 1'b0;
        else if (i_redirect)
            err_stall <= 1'b0;
        else if (push && i_ifu_resp_err)
            err_stall <= 1'b1;
    end
    assign o_inst_err = err_mem[rd_ptr];
`else
    logic unused_err;
    assign err_stall  = 1'b0;
    assign o_inst_err = 1'b0;
    assign unused_err = err_mem[rd_ptr];
`endif

    assert property (@(posedge i_clk) disable iff (i_rst) !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// tb/tb_ifu_prefetch_queue.sv - directed self-checking bench for ifu_prefetch_queue
module tb_ifu_prefetch_queue;
    localparam logic [31:0] MASK = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] raddr;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        resp_err;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, pc;
    logic        inst_err;

    int total = 0;
    int bad = 0;
    int nfire = 0;
    bit auto_resp = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] bq[$];

    always #5 clk = ~clk;

    ifu_prefetch_queue dut (
        .i_clk(clk), .i_rst(rst),
        .o_ifu_req_valid(req_valid), .i_ifu_req_ready(req_ready), .o_ifu_raddr(raddr),
        .i_ifu_resp_valid(resp_valid), .i_ifu_rdata(rdata), .i_ifu_resp_err(resp_err),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
        .o_inst(inst), .o_pc(pc), .o_inst_err(inst_err)
    );

    task automatic tick();
        bit rf, pf;
        logic [31:0] ra;
        #1;
        rf = req_valid & req_ready;
        ra = raddr;
        pf = resp_valid;
        @(posedge clk);
        #1;
        if (pf && bq.size() > 0) void'(bq.pop_front());
        if (rf) begin
            bq.push_back(ra);
            nfire++;
        end
        if (auto_resp && bq.size() > 0) begin
            resp_valid = 1'b1;
            rdata      = bq[0] ^ MASK;
            resp_err   = (bq[0] == err_addr);
        end else begin
            resp_valid = 1'b0;
            rdata      = '0;
            resp_err   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_ready = 0; resp_valid = 0; rdata = '0; resp_err = 0;
        redirect = 0; redirect_pc = '0; inst_ready = 0;
        auto_resp = 0; err_addr = 32'hFFFF_FFFF;
        bq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nfire = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_ready = 0; resp_valid = 0; rdata = '0; resp_err = 0;
        redirect = 0; redirect_pc = '0; inst_ready = 0;
        repeat (2) @(posedge clk);
        #2;
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
        total++; if (raddr !== 32'h8000_0000) begin bad++; $display("FAIL reset_raddr got=%h exp=80000000", raddr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", inst); end
        total++; if (pc !== 32'h8000_0000) begin bad++; $display("FAIL reset_pc got=%h exp=80000000", pc); end
        total++; if (inst_err !== 1'b0) begin bad++; $display("FAIL reset_inst_err got=%b exp=0", inst_err); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_req = 32'h8000_0000;
        logic [31:0] exp_pc  = 32'h8000_0000;
        int delivered = 0;
        do_reset();
        req_ready = 1; inst_ready = 1; auto_resp = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            total++;
            if (req_valid !== 1'b1 || raddr !== exp_req) begin
                bad++; $display("FAIL stream_req cyc=%0d got=%b/%h exp=1/%h", i, req_valid, raddr, exp_req);
            end
            exp_req += 4;
            if (inst_valid) begin
                total++;
                if (pc !== exp_pc || inst !== (exp_pc ^ MASK)) begin
                    bad++; $display("FAIL stream_inst got=%h/%h exp=%h/%h", pc, inst, exp_pc, exp_pc ^ MASK);
                end
                exp_pc += 4;
                delivered++;
            end
            tick();
        end
        total++; if (delivered != 10) begin bad++; $display("FAIL stream_count got=%0d exp=10", delivered); end
    endtask

    task automatic test_full();
        do_reset();
        req_ready = 1; inst_ready = 0; auto_resp = 1;
        repeat (8) tick();
        #1;
        total++; if (nfire != 4) begin bad++; $display("FAIL full_fires got=%0d exp=4", nfire); end
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL full_req_valid got=%b exp=0", req_valid); end
        total++; if (inst_valid !== 1'b1 || pc !== 32'h8000_0000) begin
            bad++; $display("FAIL full_head got=%b/%h exp=1/80000000", inst_valid, pc);
        end
        inst_ready = 1;
        #1;
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL full_pop_cycle got=%b exp=0", req_valid); end
        tick();
        inst_ready = 0;
        #1;
        total++; if (req_valid !== 1'b1 || raddr !== 32'h8000_0010) begin
            bad++; $display("FAIL full_resume got=%b/%h exp=1/80000010", req_valid, raddr);
        end
        total++; if (pc !== 32'h8000_0004) begin bad++; $display("FAIL full_next_pc got=%h exp=80000004", pc); end
    endtask

    task automatic test_stall();
        do_reset();
        req_ready = 0; auto_resp = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (req_valid !== 1'b1 || raddr !== 32'h8000_0000) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/80000000", i, req_valid, raddr);
            end
            tick();
        end
        req_ready = 1;
        #1;
        total++; if (raddr !== 32'h8000_0000) begin bad++; $display("FAIL stall_accept got=%h exp=80000000", raddr); end
        tick();
        #1;
        total++; if (raddr !== 32'h8000_0004) begin bad++; $display("FAIL stall_advance got=%h exp=80000004", raddr); end
    endtask

    task automatic test_redirect();
        bit found = 0;
        do_reset();
        req_ready = 1; inst_ready = 0; auto_resp = 0;
        repeat (3) tick();
        redirect = 1; redirect_pc = 32'h8000_1000; auto_resp = 1;
        #1;
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL redir_req_valid got=%b exp=0", req_valid); end
        tick();
        redirect = 0; inst_ready = 1;
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", inst_valid); end
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (inst_valid) begin
                found = 1;
                total++;
                if (pc !== 32'h8000_1000 || inst !== (32'h8000_1000 ^ MASK)) begin
                    bad++; $display("FAIL redir_first got=%h/%h exp=80001000/%h", pc, inst, 32'h8000_1000 ^ MASK);
                end
            end
            tick();
        end
        if (!found) begin total++; bad++; $display("FAIL redir_timeout got=none exp=80001000"); end
    endtask

    task automatic test_redirect_collide();
        bit found = 0;
        do_reset();
        req_ready = 1; inst_ready = 0; auto_resp = 1;
        repeat (3) tick();
        inst_ready = 1; redirect = 1; redirect_pc = 32'h8000_2000;
        #1;
        total++; if (inst_valid !== 1'b1 || pc !== 32'h8000_0000 || resp_valid !== 1'b1) begin
            bad++; $display("FAIL coll_setup got=%b/%h/%b exp=1/80000000/1", inst_valid, pc, resp_valid);
        end
        tick();
        redirect = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (inst_valid) begin
                found = 1;
                total++;
                if (pc !== 32'h8000_2000) begin bad++; $display("FAIL coll_next_pc got=%h exp=80002000", pc); end
            end
            tick();
        end
        if (!found) begin total++; bad++; $display("FAIL coll_timeout got=none exp=80002000"); end
    endtask

    task automatic test_err();
`ifdef IFU_ERR_TRAP_EN
        int exp_fires = 3;
        logic exp_err = 1'b1;
`else
        int exp_fires = 4;
        logic exp_err = 1'b0;
`endif
        do_reset();
        req_ready = 1; inst_ready = 0; auto_resp = 1; err_addr = 32'h8000_0004;
        repeat (6) tick();
        total++; if (nfire != exp_fires) begin bad++; $display("FAIL err_fires got=%0d exp=%0d", nfire, exp_fires); end
        inst_ready = 1;
        tick();
        inst_ready = 0;
        #1;
        total++; if (pc !== 32'h8000_0004 || inst_err !== exp_err) begin
            bad++; $display("FAIL err_head got=%h/%b exp=80000004/%b", pc, inst_err, exp_err);
        end
`ifdef IFU_ERR_TRAP_EN
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL err_stall got=%b exp=0", req_valid); end
        redirect = 1; redirect_pc = 32'h8000_3000;
        tick();
        redirect = 0;
        #1;
        total++; if (req_valid !== 1'b1 || raddr !== 32'h8000_3000) begin
            bad++; $display("FAIL err_resume got=%b/%h exp=1/80003000", req_valid, raddr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_stall();
        test_redirect();
        test_redirect_collide();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
